// File: rtl/multicycle_control_unit_pkg.sv
// ctrl_pkg: opcodes, FSM state encodings and datapath select codes shared by
// the multi-cycle control unit and its helpers.
package ctrl_pkg;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JAL    = 2'b10;
endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled cycles in a memory wait state and
// flags the cycle on which the stall budget is used up.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;

    assign stall = waiting && !mem_ready;

    // cnt_q holds the stalls already completed, so the current stall is the last allowed one at LIM
    always_comb begin
        cnt_d   = stall ? (cnt_q == LIM ? cnt_q : cnt_q + CW'(1)) : '0;
        timeout = (TIMEOUT_CYCLES != 0) && stall && (cnt_q == LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing fetch/decode/execute/memory/
// write-back for the shared-ALU, shared-memory RISC-V datapath.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SUPPORT_JAL    = 1,
    parameter int SUPPORT_LUI    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       branch,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_dbg
);
    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       waiting, timeout;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign state_dbg = state_q;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        op_d    = (state_q == S_DECODE) ? opcode : op_q;
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    OP_LD, OP_SD:   state_d = S_MEMADR;
                    OP_R, OP_ADDI:  state_d = S_EXEC;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_JAL:         state_d = (SUPPORT_JAL != 0) ? S_JAL : S_FAULT;
                    OP_LUI:         state_d = (SUPPORT_LUI != 0) ? S_LUI : S_FAULT;
                    default:        state_d = S_FAULT;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : (timeout ? S_FAULT : S_MEMRD);
            S_MEMWR:  state_d = mem_ready ? S_FETCH : (timeout ? S_FAULT : S_MEMWR);
            S_EXEC:   state_d = S_ALUWB;
            S_LUI:    state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = M2R_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        branch     = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRC_B_IMM;
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = (op_q == OP_ADDI) ? SRC_B_IMM : SRC_B_RS2;
                alu_op    = (op_q == OP_ADDI) ? ALU_ADD : ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                pc_source  = PCS_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JAL;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                instr_done = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            S_FAULT: illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: drives instruction traces into a default unit and
// a reduced unit (timeout 4, no jal/lui) and checks states and strobes per cycle.
module tb_multicycle_control_unit;
    localparam logic [6:0] I_R = 7'b0110011, I_LD = 7'b0000011, I_SD = 7'b0100011;
    localparam logic [6:0] I_BEQ = 7'b1100011, I_ADDI = 7'b0010011, I_JAL = 7'b1101111;
    localparam logic [6:0] I_LUI = 7'b0110111, I_BAD = 7'b1111111;
    localparam logic [3:0] ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4;
    localparam logic [3:0] ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7, ST_ALUWB = 8, ST_BRANCH = 9;
    localparam logic [3:0] ST_JAL = 10, ST_LUI = 11, ST_FAULT = 15;

    typedef struct packed {
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
        logic [1:0] m2r;
        logic       reg_write;
        logic [1:0] a, b, aop, pcs;
        logic       branch, illegal, done;
    } out_t;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } entry_t;

    logic       clk = 1'b0, rst_n, zero, mem_ready;
    logic [6:0] opcode;
    logic       pcw_a, irw_a, iod_a, mr_a, mw_a, rw_a, br_a, il_a, dn_a;
    logic       pcw_b, irw_b, iod_b, mr_b, mw_b, rw_b, br_b, il_b, dn_b;
    logic [1:0] m2r_a, sa_a, sb_a, aop_a, pcs_a, m2r_b, sa_b, sb_b, aop_b, pcs_b;
    logic [3:0] state_a, state_b;
    out_t       act_a, act_b;
    entry_t     tr[$];
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_a), .ir_write(irw_a), .i_or_d(iod_a), .mem_read(mr_a), .mem_write(mw_a),
        .mem_to_reg(m2r_a), .reg_write(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a),
        .pc_source(pcs_a), .branch(br_a), .illegal(il_a), .instr_done(dn_a), .state_dbg(state_a)
    );

    multicycle_control_unit #(.TIMEOUT_CYCLES(4), .SUPPORT_JAL(0), .SUPPORT_LUI(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcw_b), .ir_write(irw_b), .i_or_d(iod_b), .mem_read(mr_b), .mem_write(mw_b),
        .mem_to_reg(m2r_b), .reg_write(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b),
        .pc_source(pcs_b), .branch(br_b), .illegal(il_b), .instr_done(dn_b), .state_dbg(state_b)
    );

    assign act_a = {pcw_a, irw_a, iod_a, mr_a, mw_a, m2r_a, rw_a, sa_a, sb_a, aop_a, pcs_a, br_a, il_a, dn_a};
    assign act_b = {pcw_b, irw_b, iod_b, mr_b, mw_b, m2r_b, rw_b, sa_b, sb_b, aop_b, pcs_b, br_b, il_b, dn_b};

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic void push(input logic [3:0] s, input logic r);
        tr.push_back('{s, r});
    endfunction

    function automatic void push_fault();
        repeat (4) push(ST_FAULT, rnd());
    endfunction

    // Returns 1 when the stall budget runs out and the trace ends in FAULT.
    function automatic bit push_wait(input logic [3:0] s, input int n, input int tmo);
        if (tmo != 0 && n >= tmo) begin
            repeat (tmo) push(s, 1'b0);
            push_fault();
            return 1'b1;
        end
        repeat (n) push(s, 1'b0);
        push(s, 1'b1);
        return 1'b0;
    endfunction

    function automatic out_t exp_out(input logic [3:0] st, input logic [6:0] op, input logic r, input logic z);
        out_t o = '0;
        case (st)
            ST_FETCH:  begin o.mem_read = 1; o.b = 2'b01; o.ir_write = r; o.pc_write = r; end
            ST_DECODE: o.b = 2'b10;
            ST_MEMADR: begin o.a = 2'b01; o.b = 2'b10; end
            ST_MEMRD:  begin o.mem_read = 1; o.i_or_d = 1; end
            ST_MEMWB:  begin o.reg_write = 1; o.m2r = 2'b01; o.done = 1; end
            ST_MEMWR:  begin o.mem_write = 1; o.i_or_d = 1; o.done = r; end
            ST_EXEC:   begin o.a = 2'b01; o.b = (op == I_R) ? 2'b00 : 2'b10; o.aop = (op == I_R) ? 2'b10 : 2'b00; end
            ST_ALUWB:  begin o.reg_write = 1; o.done = 1; end
            ST_BRANCH: begin o.a = 2'b01; o.aop = 2'b01; o.branch = 1; o.pcs = 2'b01; o.pc_write = z; o.done = 1; end
            ST_JAL:    begin o.pc_write = 1; o.pcs = 2'b10; o.reg_write = 1; o.m2r = 2'b10; o.done = 1; end
            ST_LUI:    begin o.a = 2'b10; o.b = 2'b10; end
            ST_FAULT:  o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    // Expected trace for one instruction starting in FETCH; sel 1 targets the reduced unit.
    task automatic run_instr(input string tag, input bit sel, input logic [6:0] op, input logic z,
                             input int wf, input int wm, input int nmax);
        int   tmo = sel ? 4 : 16;
        bit   full = !sel;
        logic [3:0] st;
        out_t act, exp;
        tr.delete();
        if (!push_wait(ST_FETCH, wf, tmo)) begin
            push(ST_DECODE, rnd());
            case (op)
                I_LD: begin push(ST_MEMADR, rnd()); if (!push_wait(ST_MEMRD, wm, tmo)) push(ST_MEMWB, rnd()); end
                I_SD: begin push(ST_MEMADR, rnd()); void'(push_wait(ST_MEMWR, wm, tmo)); end
                I_R, I_ADDI: begin push(ST_EXEC, rnd()); push(ST_ALUWB, rnd()); end
                I_BEQ: push(ST_BRANCH, rnd());
                I_JAL: if (full) push(ST_JAL, rnd()); else push_fault();
                I_LUI: if (full) begin push(ST_LUI, rnd()); push(ST_ALUWB, rnd()); end else push_fault();
                default: push_fault();
            endcase
        end
        foreach (tr[i]) begin
            if (nmax >= 0 && i >= nmax) break;
            @(negedge clk);
            mem_ready = tr[i].rdy;
            opcode    = (tr[i].st == ST_DECODE) ? op : 7'($urandom);
            zero      = (tr[i].st == ST_BRANCH) ? z : rnd();
            #1;
            st  = sel ? state_b : state_a;
            act = sel ? act_b : act_a;
            exp = exp_out(tr[i].st, op, tr[i].rdy, z);
            n_cmp++;
            if (st !== tr[i].st) begin
                n_err++;
                $display("FAIL %s cyc %0d state: got %0d want %0d", tag, i, st, tr[i].st);
            end
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s cyc %0d outputs(st %0d): got %05h want %05h", tag, i, tr[i].st, act, exp);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state_a !== ST_IDLE || act_a !== '0) begin
            n_err++;
            $display("FAIL %s reset_a: got st %0d out %05h want 0/0", tag, state_a, act_a);
        end
        n_cmp++;
        if (state_b !== ST_IDLE || act_b !== '0) begin
            n_err++;
            $display("FAIL %s reset_b: got st %0d out %05h want 0/0", tag, state_b, act_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (state_a !== ST_IDLE || act_a !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got st %0d out %05h want 0/0", state_a, act_a);
        end
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (state_a !== ST_IDLE || act_a !== '0) begin
            n_err++;
            $display("FAIL reset_edges: got st %0d out %05h want 0/0", state_a, act_a);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (state_a !== ST_IDLE || act_a !== '0) begin
            n_err++;
            $display("FAIL idle_after_release: got st %0d out %05h want 0/0", state_a, act_a);
        end
    endtask

    task automatic test_r_type();
        run_instr("r_type", 0, I_R, 0, 0, 0, -1);
        run_instr("addi", 0, I_ADDI, 0, 0, 0, -1);
        run_instr("lui", 0, I_LUI, 0, 0, 0, -1);
    endtask

    task automatic test_load_store();
        run_instr("ld_wait2", 0, I_LD, 0, 0, 2, -1);
        run_instr("sd_wait1", 0, I_SD, 0, 1, 1, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 0, I_BEQ, 1, 0, 0, -1);
        run_instr("beq_not", 0, I_BEQ, 0, 0, 0, -1);
    endtask

    task automatic test_jal();
        run_instr("jal_on", 0, I_JAL, 0, 0, 0, -1);
        do_reset("jal");
        run_instr("jal_off", 1, I_JAL, 0, 0, 0, -1);
        do_reset("jal_off_clear");
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 0, I_BAD, 0, 0, 0, -1);
        do_reset("illegal_clear");
    endtask

    task automatic test_timeout();
        run_instr("ready_wins", 1, I_R, 0, 3, 0, -1);
        run_instr("fetch_timeout", 1, I_R, 0, 4, 0, -1);
        do_reset("timeout_clear");
        run_instr("memwr_timeout", 1, I_SD, 0, 0, 6, -1);
        do_reset("memwr_timeout_clear");
        run_instr("memrd_edge", 1, I_LD, 0, 0, 3, -1);
    endtask

    task automatic test_reset_mid();
        do_reset("mid_pre");
        run_instr("sd_partial", 0, I_SD, 0, 0, 2, 4);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (state_a !== ST_IDLE || act_a !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got st %0d out %05h want 0/0", state_a, act_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (state_a !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_release: got st %0d want 0", state_a);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (state_a !== ST_FETCH) begin
            n_err++;
            $display("FAIL reset_mid_fetch: got st %0d want 1", state_a);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[7] = '{I_R, I_LD, I_SD, I_BEQ, I_ADDI, I_JAL, I_LUI};
        do_reset("rand_pre");
        for (int k = 0; k < 80; k++)
            run_instr("random", 0, ops[$urandom_range(0, 6)], rnd(), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
    endtask

    initial begin
        rst_n = 1'b0;
        zero = 1'b0;
        mem_ready = 1'b0;
        opcode = '0;
        test_reset();
        test_r_type();
        test_load_store();
        test_branch();
        test_jal();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style FSM control unit for the multi-cycle RISC-V datapath, replacing the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one memory port. It waits on a memory ready handshake with a configurable timeout, and extends the instruction set with optional jal and lui. It sits between the instruction register (opcode field), the ALU zero flag, and the datapath mux/enable inputs.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive mem_ready=0 cycles in a wait state before FAULT; 0 disables timeout
SUPPORT_JAL, 1, 1 enables jal (1101111); 0 treats it as illegal
SUPPORT_LUI, 1, 1 enables lui (0110111); 0 treats it as illegal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction[6:0] from the IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed the current read/write this cycle
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  2  write-back select: 00=ALUOut, 01=MDR, 10=PC
reg_write  out  1  register file write enable
alu_src_a  out  2  ALU A select: 00=PC, 01=rs1, 10=zero
alu_src_b  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm
alu_op  out  2  00=add, 01=sub/compare, 10=funct-decoded
pc_source  out  2  PC select: 00=ALU result, 01=ALUOut, 10=jal target
branch  out  1  beq evaluation cycle
illegal  out  1  high while in FAULT
instr_done  out  1  one-cycle pulse in the final state of each instruction
state_dbg  out  4  current state encoding

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, op_q=0, wait counter=0. All outputs are 0 while in reset and in IDLE. The first rising edge after release moves the FSM to FETCH.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, FAULT 15.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready (combinational).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Latches opcode into op_q.
  - Next state: 0000011/0100011 -> MEMADR; 0110011/0010011 -> EXEC; 1100011 -> BRANCH; jal -> JAL; lui -> LUI; anything else -> FAULT.
- MEMADR: alu_src_a=01, alu_src_b=10, alu_op=00. Next is MEMRD if op_q is ld, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=01, instr_done=1. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. instr_done=mem_ready. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a=01. For R-type: alu_src_b=00, alu_op=10. For addi: alu_src_b=10, alu_op=00. Next ALUWB.
- ALUWB: reg_write=1, mem_to_reg=00, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, branch=1, pc_source=01, pc_write=zero, instr_done=1. Next FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, mem_to_reg=10 (PC already holds PC+4), instr_done=1. Next FETCH.
- LUI: alu_src_a=10, alu_src_b=10, alu_op=00. Next ALUWB.
- FAULT: illegal=1. Held until reset; no memory or register strobes.
- Latency in cycles with mem_ready always 1:
  - R/addi 4, ld 5, sd 4, beq 3, jal 3, lui 4.
  - Each wait cycle adds 1.
- Timeout:
  - The counter increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0, and clears on leaving the state.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero), the next state is FAULT instead.
  - mem_ready=1 on the same cycle wins over timeout.
- Opcode changes outside DECODE are ignored (op_q is used).
- Reset mid-instruction aborts immediately; no strobes are emitted after rst_n falls.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants (R, LD, SD, BEQ, ADDI, JAL, LUI)
  - state enum/encodings
  - ALUOp codes
  - mem_to_reg, alu_src_a, alu_src_b and pc_source select encodings
- Sub-module mem_wait_timer (counter + timeout compare, parameter TIMEOUT_CYCLES).
- FSM next-state and output decode stay in the top.

Test Plan:
- Reset, release, mem_ready=1, opcode=0110011 -> states 0,1,2,7,8,1. EXEC shows alu_op=10, alu_src_b=00; ALUWB shows reg_write=1 and instr_done pulse.
- ld (0000011) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with mem_to_reg=01, reg_write=1. Total 7 cycles.
- beq with zero=1, then beq with zero=0 -> pc_write=1/pc_source=01 in the first BRANCH cycle; pc_write=0 in the second.
- jal with SUPPORT_JAL=1 -> JAL state with pc_source=10, mem_to_reg=10. Same opcode with SUPPORT_JAL=0 -> FAULT, illegal=1 held until rst_n=0.
- Opcode 1111111 -> FAULT after DECODE. TIMEOUT_CYCLES=4 with mem_ready=0 in FETCH -> FAULT after 4 wait cycles, never ir_write.
- rst_n asserted during MEMWR -> outputs 0 and state_dbg=0 immediately (asynchronous); FETCH follows one cycle after release.
